// File: rtl/bus_pkg.sv
// Shared types and constants for the processor-bus memory responder.
package bus_pkg;

  // Width of one bus data word.
  localparam int BUS_WORD_W = 32;

  // Width of the wait-state counter. It covers 0..15 extra cycles.
  localparam int BUS_WAIT_CNT_W = 4;

  // Default read data returned for addresses outside the memory window.
  localparam logic [BUS_WORD_W-1:0] BUS_ERROR_DATA_DEFAULT = 32'hFFFF_FFFF;

  // Responder transaction states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2,
    ST_RECOVER = 2'd3
  } bus_state_e;

endpackage : bus_pkg

// File: rtl/bus_responder_ram.sv
// Single-port synchronous word RAM with a registered read and no reset.
// The read port samples every cycle, so the data for the address presented
// on one edge is available after that edge.
module bus_responder_ram
  import bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                  i_clock,
  input  logic                  write_enable_i,
  input  logic [ADDR_W-1:0]     address_i,
  input  logic [BUS_WORD_W-1:0] data_write_i,
  output logic [BUS_WORD_W-1:0] data_read_o
);

  logic [BUS_WORD_W-1:0] mem_q [DEPTH_WORDS];

  // Write when enabled; read the addressed word into the output register.
  always_ff @(posedge i_clock) begin
    if (write_enable_i) begin
      mem_q[address_i] <= data_write_i;
    end
    data_read_o <= mem_q[address_i];
  end

endmodule : bus_responder_ram

// File: rtl/bus_memory_responder.sv
// Bus target that services one code/data transaction at a time from an
// internal word memory, with programmable wait states, a one-cycle ready
// pulse, registered read data, an out-of-range error flag and a busy flag.
module bus_memory_responder
  import bus_pkg::*;
#(
  parameter logic [31:0]           ADDRESS_BASE = 32'h0000_0000,
  parameter int                    DEPTH_WORDS  = 1024,
  parameter int                    WAIT_STATES  = 2,
  parameter logic [BUS_WORD_W-1:0] ERROR_DATA   = BUS_ERROR_DATA_DEFAULT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_bus_vaild,
  output logic                  o_bus_ready,
  output logic                  o_bus_busy,
  input  logic                  i_bus_write_enable,
  input  logic [31:0]           i_bus_address,
  output logic [BUS_WORD_W-1:0] o_bus_data_read,
  input  logic [BUS_WORD_W-1:0] i_bus_data_write,
  output logic                  o_bus_error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [BUS_WAIT_CNT_W-1:0] WAIT_LOAD = BUS_WAIT_CNT_W'(WAIT_STATES);
  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

  bus_state_e                state_q;
  logic [BUS_WAIT_CNT_W-1:0] counter_q;
  logic                      write_enable_q;
  logic [31:0]               address_q;
  logic [BUS_WORD_W-1:0]     data_write_q;
  logic                      ready_q;
  logic                      busy_q;
  logic                      error_q;
  logic [BUS_WORD_W-1:0]     data_read_q;

  logic [31:0]           live_offset;
  logic [31:0]           cap_offset;
  logic [31:0]           live_word;
  logic [31:0]           cap_word;
  logic                  cap_in_range;
  logic                  access_edge;
  logic [IDX_W-1:0]      ram_address;
  logic                  ram_write_enable;
  logic [BUS_WORD_W-1:0] ram_data_read;

  // Range check and word index. The captured address decides the access;
  // while idle the live bus address steers the RAM so that its registered
  // read already holds the right word when a zero-wait access completes.
  // The unsigned subtraction makes addresses below the base look huge, so
  // they fail the depth test instead of aliasing into the array.
  always_comb begin
    live_offset      = i_bus_address - ADDRESS_BASE;
    cap_offset       = address_q - ADDRESS_BASE;
    live_word        = live_offset >> 2;
    cap_word         = cap_offset >> 2;
    cap_in_range     = (address_q >= ADDRESS_BASE) && (cap_word < DEPTH_LIMIT);
    access_edge      = (state_q == ST_WAIT) && (counter_q == '0);
    ram_write_enable = access_edge && write_enable_q && cap_in_range;
    if (state_q == ST_IDLE) begin
      ram_address = live_word[IDX_W-1:0];
    end else begin
      ram_address = cap_word[IDX_W-1:0];
    end
  end

  bus_responder_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (IDX_W)
  ) u_ram (
    .i_clock        (i_clock),
    .write_enable_i (ram_write_enable),
    .address_i      (ram_address),
    .data_write_i   (data_write_q),
    .data_read_o    (ram_data_read)
  );

  // Transaction FSM: capture, count wait states, respond for one cycle,
  // then a recovery cycle that ignores the initiator's lingering valid.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= ST_IDLE;
      counter_q      <= '0;
      write_enable_q <= 1'b0;
      address_q      <= '0;
      data_write_q   <= '0;
      ready_q        <= 1'b0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
      data_read_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_bus_vaild) begin
            write_enable_q <= i_bus_write_enable;
            address_q      <= i_bus_address;
            data_write_q   <= i_bus_data_write;
            counter_q      <= WAIT_LOAD;
            busy_q         <= 1'b1;
            state_q        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (counter_q == '0) begin
            // Access edge: the RAM write fires combinationally alongside
            // this; reads take the word the RAM registered last edge.
            ready_q <= 1'b1;
            error_q <= ~cap_in_range;
            if (!write_enable_q) begin
              data_read_q <= cap_in_range ? ram_data_read : ERROR_DATA;
            end
            state_q <= ST_RESPOND;
          end else begin
            counter_q <= counter_q - 1'b1;
          end
        end
        ST_RESPOND: begin
          ready_q <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_RECOVER;
        end
        ST_RECOVER: begin
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_bus_ready     = ready_q;
  assign o_bus_busy      = busy_q;
  assign o_bus_error     = error_q;
  assign o_bus_data_read = data_read_q;

endmodule : bus_memory_responder

// File: tb/tb_bus_memory_responder.sv
// Scoreboard bench for bus_memory_responder: instance A uses two wait states,
// instance B uses zero wait states. Stimulus pushes expected responses; one
// monitor per instance pops and compares on every ready pulse.
module tb_bus_memory_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        valid_a = 1'b0, we_a = 1'b0;
  logic [31:0] addr_a = '0, wdata_a = '0;
  logic        ready_a, busy_a, err_a;
  logic [31:0] rdata_a;

  logic        valid_b = 1'b0, we_b = 1'b0;
  logic [31:0] addr_b = '0, wdata_b = '0;
  logic        ready_b, busy_b, err_b;
  logic [31:0] rdata_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bus_memory_responder #(
    .ADDRESS_BASE (32'h0000_0000), .DEPTH_WORDS (1024),
    .WAIT_STATES  (2),             .ERROR_DATA  (32'hFFFF_FFFF)
  ) dut_a (
    .i_clock (clk), .i_reset (rst), .i_bus_vaild (valid_a),
    .o_bus_ready (ready_a), .o_bus_busy (busy_a),
    .i_bus_write_enable (we_a), .i_bus_address (addr_a),
    .o_bus_data_read (rdata_a), .i_bus_data_write (wdata_a),
    .o_bus_error (err_a)
  );

  bus_memory_responder #(
    .ADDRESS_BASE (32'h0000_0000), .DEPTH_WORDS (1024),
    .WAIT_STATES  (0),             .ERROR_DATA  (32'hFFFF_FFFF)
  ) dut_b (
    .i_clock (clk), .i_reset (rst), .i_bus_vaild (valid_b),
    .o_bus_ready (ready_b), .o_bus_busy (busy_b),
    .i_bus_write_enable (we_b), .i_bus_address (addr_b),
    .o_bus_data_read (rdata_b), .i_bus_data_write (wdata_b),
    .o_bus_error (err_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor for instance A.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ready_a) begin
        if (q_a.size() == 0) begin
          check("a_phantom_ready", 32'd1, 32'd0);
        end else begin
          e = q_a.pop_front();
          check("a_error", 32'(err_a), 32'(e.err));
          if (e.chk_data) check("a_data", rdata_a, e.data);
          $display("A resp: data=%h err=%0d", rdata_a, err_a);
        end
      end
    end
  end

  // Monitor for instance B.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ready_b) begin
        if (q_b.size() == 0) begin
          check("b_phantom_ready", 32'd1, 32'd0);
        end else begin
          e = q_b.pop_front();
          check("b_error", 32'(err_b), 32'(e.err));
          if (e.chk_data) check("b_data", rdata_b, e.data);
          $display("B resp: data=%h err=%0d", rdata_b, err_b);
        end
      end
    end
  end

  task automatic drive(input int sel, input logic v, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      valid_a = v; we_a = w; addr_a = a; wdata_a = d;
    end else begin
      valid_b = v; we_b = w; addr_b = a; wdata_b = d;
    end
  endtask

  // One complete transaction. addr_after replaces the address right after
  // capture; hold keeps valid high through the recovery edge as well.
  task automatic xact(input int sel, input int ws, input logic w,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] addr_after,
                      input logic [31:0] exp_d, input logic exp_e,
                      input logic chk_d, input logic hold);
    exp_t e;
    int   k;
    logic seen;
    logic rdy, bsy;
    e.data = exp_d; e.err = exp_e; e.chk_data = chk_d;
    @(negedge clk);
    drive(sel, 1'b1, w, addr, wd);
    if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
    @(posedge clk);
    #1;
    if (sel == 0) addr_a = addr_after; else addr_b = addr_after;
    k = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      rdy = (sel == 0) ? ready_a : ready_b;
      bsy = (sel == 0) ? busy_a : busy_b;
      if (k == 0) check("busy_after_capture", 32'(bsy), 32'd1);
      if (rdy) seen = 1'b1; else k++;
    end
    if (!seen) check("ready_timeout", 32'd0, 32'd1);
    else       check("ready_latency", 32'(k), 32'(ws + 1));
    @(posedge clk);
    #1;
    if (!hold) drive(sel, 1'b0, w, addr_after, wd);
    @(negedge clk);
    rdy = (sel == 0) ? ready_a : ready_b;
    bsy = (sel == 0) ? busy_a : busy_b;
    check("ready_single_pulse", 32'(rdy), 32'd0);
    check("busy_after_respond", 32'(bsy), 32'd0);
    if (chk_d) check("data_held", (sel == 0) ? rdata_a : rdata_b, exp_d);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, w, addr_after, wd);
    $display("%s xact sel=%0d we=%0d addr=%h wd=%h exp=%h err=%0d",
             (sel == 0) ? "A" : "B", sel, w, addr, wd, exp_d, exp_e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready_a", 32'(ready_a), 32'd0);
    check("rst_busy_a",  32'(busy_a),  32'd0);
    check("rst_data_a",  rdata_a,      32'd0);
    check("rst_err_a",   32'(err_a),   32'd0);
    check("rst_ready_b", 32'(ready_b), 32'd0);
    rst = 1'b0;
    $display("reset released");

    //   sel ws we addr           wdata          addr_after     exp_data       err chk hold
    xact(0, 2, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_0000, 0, 1, 0);
    xact(0, 2, 0, 32'h0000_0010, 32'h0,         32'h0000_0010, 32'hDEAD_BEEF, 0, 1, 0);
    xact(0, 2, 1, 32'h0000_0000, 32'hA5A5_0000, 32'h0000_0000, 32'hDEAD_BEEF, 0, 1, 0);
    xact(0, 2, 0, 32'h0000_1000, 32'h0,         32'h0000_1000, 32'hFFFF_FFFF, 1, 1, 0);
    xact(0, 2, 1, 32'h0000_1000, 32'h0BAD_0BAD, 32'h0000_1000, 32'h0,         1, 0, 0);
    xact(0, 2, 0, 32'h0000_0000, 32'h0,         32'h0000_0000, 32'hA5A5_0000, 0, 1, 0);
    xact(0, 2, 0, 32'h0000_0003, 32'h0,         32'h0000_0003, 32'hA5A5_0000, 0, 1, 0);
    xact(0, 2, 1, 32'h0000_0FFC, 32'h0F0F_0FFC, 32'h0000_0FFC, 32'hA5A5_0000, 0, 1, 0);
    xact(0, 2, 0, 32'h0000_0FFC, 32'h0,         32'h0000_0FFC, 32'h0F0F_0FFC, 0, 1, 0);
    xact(0, 2, 0, 32'h0000_0010, 32'h0,         32'h0000_0010, 32'hDEAD_BEEF, 0, 1, 1);
    xact(0, 2, 0, 32'h0000_0000, 32'h0,         32'h0000_0000, 32'hA5A5_0000, 0, 1, 0);
    xact(0, 2, 1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0020, 32'hA5A5_0000, 0, 1, 0);

    // Write to 0x20 aborted by reset while waiting; nothing is queued.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_busy",  32'(busy_a),  32'd0);
    check("async_rst_ready", 32'(ready_a), 32'd0);
    check("async_rst_data",  rdata_a,      32'd0);
    check("async_rst_err",   32'(err_a),   32'd0);
    $display("reset asserted during write wait");
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    xact(0, 2, 0, 32'h0000_0020, 32'h0,         32'h0000_0020, 32'h1234_5678, 0, 1, 0);

    xact(1, 0, 1, 32'h0000_0004, 32'h1111_0004, 32'h0000_0004, 32'h0000_0000, 0, 1, 0);
    xact(1, 0, 1, 32'h0000_0008, 32'h2222_0008, 32'h0000_0008, 32'h0000_0000, 0, 1, 0);
    xact(1, 0, 0, 32'h0000_0004, 32'h0,         32'h0000_0008, 32'h1111_0004, 0, 1, 0);
    xact(1, 0, 0, 32'h0000_0008, 32'h0,         32'h0000_0008, 32'h2222_0008, 0, 1, 0);

    repeat (8) @(negedge clk);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bus_memory_responder
